// File: rtl/serial_deser_pkg.sv
// Shared types for the serial deserializer: framing FSM state encoding.
package serial_deser_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } deser_state_t;

endpackage

// File: rtl/serial_deser.sv
// Serial-to-parallel deserializer: start-aligned framing, WIDTH-bit shift register,
// valid/ready output register with sticky overrun flag.
module serial_deser
  import serial_deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d,
  input  logic             bit_en,
  input  logic             start,
  input  logic             ready,
  input  logic             clr_overrun,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             overrun,
  output logic [CW-1:0]    bit_cnt
);

  deser_state_t     state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first_word;
  logic             complete;
  logic             realign;

  always_comb begin
    shifted    = '0;
    first_word = '0;
    if (MSB_FIRST) begin
      shifted    = {shreg[WIDTH-2:0], d};
      first_word = {{(WIDTH-1){1'b0}}, d};
    end else begin
      shifted    = {d, shreg[WIDTH-1:1]};
      first_word = {d, {(WIDTH-1){1'b0}}};
    end
  end

  // A start pulse outranks completion, so the realigned bit never finishes a stale word.
  assign realign  = bit_en && start;
  assign complete = (state == SHIFT) && bit_en && !start && (bit_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (realign) begin
      state   <= SHIFT;
      shreg   <= first_word;
      bit_cnt <= CW'(1);
    end else if ((state == SHIFT) && bit_en) begin
      shreg   <= shifted;
      bit_cnt <= complete ? '0 : bit_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (complete) begin
        if (!valid || ready) begin
          data_out <= shifted;
          valid    <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end

      if (complete && valid && !ready) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_deser.sv
// Directed bench: MSB-first and LSB-first deserializers fed the same serial stream.
module tb_serial_deser;

  logic       clk = 1'b0;
  logic       reset, d, bit_en, start, ready, clr_overrun;
  logic [7:0] dm, dl;
  logic       vm, vl, om, ol;
  logic [2:0] cm, cl;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  serial_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .d(d), .bit_en(bit_en), .start(start), .ready(ready),
    .clr_overrun(clr_overrun), .data_out(dm), .valid(vm), .overrun(om), .bit_cnt(cm)
  );

  serial_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .d(d), .bit_en(bit_en), .start(start), .ready(ready),
    .clr_overrun(clr_overrun), .data_out(dl), .valid(vl), .overrun(ol), .bit_cnt(cl)
  );

  function automatic logic [7:0] rev8(input logic [7:0] w);
    for (int unsigned i = 0; i < 8; i++) rev8[i] = w[7-i];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with no strobe; d and start toggle freely since they must be ignored.
  task automatic idle();
    bit_en = 1'b0;
    d      = 1'($urandom_range(0, 1));
    start  = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Sends the first n bits of w, w[7] first; start on the first bit when st=1.
  task automatic send_bits(input logic [7:0] w, input int n, input bit st, input int gap);
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (gap) idle();
      d      = w[7-i];
      bit_en = 1'b1;
      start  = (i == 0) ? st : 1'b0;
      @(posedge clk);
      #1;
      bit_en = 1'b0;
      start  = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; d = 1'b0; bit_en = 1'b0; start = 1'b0; ready = 1'b1; clr_overrun = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", dm, 8'h00);
    chk("rst_valid", vm, 1'b0);
    chk("rst_overrun", om, 1'b0);
    chk("rst_bitcnt", cm, 3'd0);
    reset = 1'b0;

    // Bits without start are ignored in IDLE
    bit_en = 1'b1; d = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bit_en = 1'b0;
    chk("idle_ignore_cnt", cm, 3'd0);

    // Basic word
    send_bits(8'hA5, 1, 1'b1, 0);
    chk("basic_cnt1", cm, 3'd1);
    send_bits(8'h4A, 7, 1'b0, 0);  // remaining bits 0,1,0,0,1,0,1
    chk("basic_valid", vm, 1'b1);
    chk("basic_data", dm, 8'hA5);
    chk("basic_cnt0", cm, 3'd0);
    chk("lsb_data", dl, 8'hA5);
    chk("lsb_valid", vl, 1'b1);
    idle();
    chk("basic_valid_drop", vm, 1'b0);
    chk("basic_data_hold", dm, 8'hA5);

    // Back-to-back with strobe gaps
    send_bits(8'h3C, 8, 1'b1, 2);
    chk("b2b_w1_valid", vm, 1'b1);
    chk("b2b_w1_data", dm, 8'h3C);
    chk("b2b_w1_lsb", dl, rev8(8'h3C));
    send_bits(8'hC3, 1, 1'b0, 2);
    idle();
    chk("b2b_gap_cnt_hold", cm, 3'd1);
    chk("b2b_valid_dropped", vm, 1'b0);
    idle();
    send_bits(8'h86, 7, 1'b0, 2);  // remaining bits of C3
    chk("b2b_w2_valid", vm, 1'b1);
    chk("b2b_w2_data", dm, 8'hC3);
    chk("b2b_w2_lsb", dl, rev8(8'hC3));
    chk("b2b_overrun", om, 1'b0);
    idle();

    // Backpressure
    ready = 1'b0;
    send_bits(8'h11, 8, 1'b1, 0);
    chk("bp_w1_data", dm, 8'h11);
    chk("bp_w1_overrun", om, 1'b0);
    send_bits(8'h22, 8, 1'b0, 0);
    chk("bp_data_hold", dm, 8'h11);
    chk("bp_valid_hold", vm, 1'b1);
    chk("bp_overrun", om, 1'b1);
    chk("bp_overrun_lsb", ol, 1'b1);
    idle();
    chk("bp_overrun_sticky", om, 1'b1);
    clr_overrun = 1'b1;
    idle();
    clr_overrun = 1'b0;
    chk("bp_overrun_clr", om, 1'b0);
    chk("bp_valid_after_clr", vm, 1'b1);
    ready = 1'b1;
    idle();
    chk("bp_accept", vm, 1'b0);

    // Realign after a 5-bit partial word
    send_bits(8'hFF, 5, 1'b1, 0);
    chk("realign_cnt5", cm, 3'd5);
    send_bits(8'h5A, 8, 1'b1, 0);
    chk("realign_valid", vm, 1'b1);
    chk("realign_data", dm, 8'h5A);
    chk("realign_overrun", om, 1'b0);
    idle();

    // Start on what would have been the 8th bit restarts instead of completing
    send_bits(8'hFE, 7, 1'b1, 0);
    send_bits(8'h80, 1, 1'b1, 0);
    chk("startprio_valid", vm, 1'b0);
    chk("startprio_cnt", cm, 3'd1);
    chk("startprio_data", dm, 8'h5A);

    // Reset mid-word
    send_bits(8'hF0, 4, 1'b1, 0);
    chk("midrst_cnt4", cm, 3'd4);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midrst_data", dm, 8'h00);
    chk("midrst_valid", vm, 1'b0);
    chk("midrst_cnt", cm, 3'd0);
    chk("midrst_lsb_data", dl, 8'h00);
    send_bits(8'hFF, 8, 1'b0, 0);
    send_bits(8'h0F, 4, 1'b0, 0);
    chk("midrst_no_valid", vm, 1'b0);
    chk("midrst_no_cnt", cm, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_deser.md
# serial_deser

Serial-to-parallel deserializer that consumes the registered bit stream produced by the single-bit D flip-flop input stage (its `q` drives `d` here). It collects WIDTH bits qualified by a sample strobe, aligns frames on a `start` pulse, and presents each completed word through a valid/ready output register with a sticky overrun flag. It sits between the bit-level capture flop and any word-level consumer.

## Interface
- WIDTH, 8, bits per word; legal range 2–32.
- MSB_FIRST, 1, 1: first received bit lands in `data_out[WIDTH-1]`; 0: first bit lands in `data_out[0]`.
- CW, $clog2(WIDTH), derived local parameter; never overridden.

- clk  input  1  single clock; all logic rising-edge.
- reset  input  1  synchronous, active-high; clears all state on the clock edge where it is high.
- d  input  1  serial data bit, driven by the upstream flop's `q`.
- bit_en  input  1  sample strobe; `d` is consumed only on cycles where `bit_en`=1.
- start  input  1  frame align; meaningful only together with `bit_en`.
- ready  input  1  downstream accepts `data_out` when `valid`&&`ready`.
- clr_overrun  input  1  clears `overrun`.
- data_out  output  WIDTH  last completed word; held stable while `valid`=1.
- valid  output  1  word available.
- overrun  output  1  sticky; a completed word was dropped.
- bit_cnt  output  CW  bits collected in the current word.

## Operation
- FSM states: IDLE (unaligned, bits ignored), SHIFT (collecting).
- IDLE: `bit_en`&&`start` -> capture `d` as bit 0 of a new word, `bit_cnt`=1, go to SHIFT. `bit_en` without `start` -> ignored.
- SHIFT: `bit_en` -> shift `d` in, `bit_cnt`++. On the WIDTH-th bit (`bit_cnt`==WIDTH-1 with `bit_en`): word complete, `bit_cnt` -> 0, stay in SHIFT, so back-to-back words continue with no gap.
- `start`&&`bit_en` in SHIFT: the partial word is discarded without a flag. `d` becomes bit 0 of a new word and `bit_cnt`=1. This takes priority over completion in the same cycle.
- Completion with `valid`=0: load the output register, `valid`=1.
- Completion with `valid`=1 and `ready`=1: load the new word, `valid` stays 1, no overrun.
- Completion with `valid`=1 and `ready`=0: the new word is dropped, `data_out` is unchanged, `overrun`=1.
- `valid`&&`ready` with no completion: `valid` -> 0. `data_out` keeps its value.
- `overrun` is cleared by `clr_overrun` or `reset`. If a set event and `clr_overrun` occur in the same cycle, the set wins.
- Bit order: with MSB_FIRST=1, shift left and insert at the LSB. With MSB_FIRST=0, shift right and insert at the MSB. Either way the WIDTH-th bit completes the word with no further realignment.

## Timing
- Reset values: `data_out`=0, `valid`=0, `overrun`=0, `bit_cnt`=0, state IDLE, shift register 0.
- Reset mid-word: the partial word is lost. A subsequent word needs a new `start`.
- Latency: the WIDTH-th `bit_en` at edge N -> `valid`=1 and `data_out` updated after edge N (visible in cycle N+1).
- `valid` deasserts in the cycle after the accepting edge, unless a new word loads on that same edge.
- `bit_en` gaps of any length are allowed. State and `bit_cnt` hold while `bit_en`=0.
- `bit_cnt` is registered and updates one edge after its qualifying `bit_en`.
- Outputs are purely registered. There is no combinational path from inputs to outputs.

## Structure
- Package `serial_deser_pkg` holds the FSM state enum typedef (IDLE, SHIFT).
- The block is a single module with no sub-module. The shift register, counter, FSM and output register together fit comfortably in one file.

## Test plan
All scenarios use WIDTH=8 unless stated.
- Basic word (MSB_FIRST=1, `ready`=1): `start` on the first bit, then feed 1,0,1,0,0,1,0,1 with `bit_en` every cycle. Required: `data_out`=8'hA5 and `valid`=1 one cycle after the 8th bit, then `valid`=0 on the next cycle.
- Back-to-back words with `bit_en` gaps (`bit_en` every third cycle): send 8'h3C, then 8'hC3 with no second `start`. Required: both words are delivered in order and `overrun` stays 0.
- Backpressure: hold `ready`=0 and send 8'h11 then 8'h22. Required: `data_out` stays 8'h11 and `overrun`=1 after the second word completes. Then pulse `clr_overrun`. Required: `overrun`=0.
- Realign: send `start` and 5 bits, then issue `start` again and send 8'h5A. Required: a single word 8'h5A is delivered and `overrun` stays 0.
- Reset mid-word: assert `reset` after 4 bits. Required: all outputs return to 0 on the next edge. Bits sent afterwards without `start` produce no `valid`.
- LSB-first variant (MSB_FIRST=0): feed the bit sequence 1,0,1,0,0,1,0,1. Required: `data_out`=8'hA5 (first bit in bit 0).
